oc_dispatch_ctrl: RTL and testbench
===================================

# oc_dispatch_ctrl

Parametrised operand-collector dispatch controller for the GPGPU register-read stage. It accepts one decoded instruction at a time from the issue unit and allocates a free operand collector (OC) round-robin. It translates up to two source-register indices through a programmable warp-to-physical mapping table into bank/row addresses and issues the bank read requests on two independent handshaked ports, serialising operand B when both operands hit the same bank. OC occupancy is tracked internally and freed by explicit release from the collectors.

## Interface
- NUM_OC, 4, number of operand collectors (2..16); OC_W = clog2(NUM_OC)
- NUM_WARP, 8, hardware warps (power of 2); WARP_W = clog2(NUM_WARP)
- ROW_W, 3, register-file row address width; table entry width EW = ROW_W+1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  instruction accepted when both high
- instr  in  32  rs_a = instr[23:21], rs_b = instr[18:16], src_b_en = instr[24]
- hw_warp  in  WARP_W  warp of offered instruction
- lut_we  in  1  mapping-table write strobe
- lut_waddr  in  WARP_W+2  table entry index
- lut_wdata  in  EW  entry: [EW-1:1] row, [0] bank MSB
- oc_release_valid  in  1  collector finished
- oc_release_id  in  OC_W  collector being freed
- req_a_valid / req_b_valid  out  1  operand A / B bank read request
- req_a_ready / req_b_ready  in  1  bank arbiter accepts
- req_a_bank / req_b_bank  out  2  bank id
- req_a_row / req_b_row  out  ROW_W  row id
- req_ocid  out  OC_W  collector owning current requests
- oc_busy  out  NUM_OC  occupancy vector

## Operation
- Table: NUM_WARP*4 entries; reset value entry[i] = i mod 2^EW. Write on lut_we at clock edge.
- Mapping of register r (3 bits) for warp w: e = table[w*4 + r[2:1]]; bank = {e[0], r[0]}; row = e[EW-1:1].
- States IDLE, ISSUE. instr_ready = (state==IDLE) && (oc_busy != all ones); combinational.
- Accept (IDLE, valid&&ready): allocate first free OC searching upward from rr_ptr with wrap; set its busy bit; rr_ptr <= alloc+1 mod NUM_OC; register ocid, bank/row A and B; pend_a <= 1, pend_b <= src_b_en; go ISSUE.
- ISSUE: req_a_valid = pend_a; conflict = pend_b && (bank_a == bank_b); req_b_valid = pend_b && !(conflict && pend_a). A handshake clears pend_a, B handshake clears pend_b; both may complete same cycle. When neither pend remains after the edge, state <= IDLE.
- Release: oc_release_valid clears oc_busy[oc_release_id] at the edge; release of a non-busy OC is ignored; freed OC is allocatable from the next cycle (no same-cycle bypass into instr_ready).
- Request outputs hold stable while valid and not ready.

## Timing
- Reset: state IDLE, oc_busy 0, rr_ptr 0, pend_a/pend_b 0, all req_* valid 0, bank/row/ocid 0, table identity; instr_ready 1 after reset deasserts.
- Accept at edge T -> req_a_valid (and req_b_valid if no conflict) high in cycle T+1.
- Conflict: B valid the cycle after A handshakes (earliest T+2).
- Last handshake at edge U -> IDLE, instr_ready high in cycle U+1 if an OC is free. Peak throughput one instruction per 2 cycles.
- Table write at same edge as accept: lookup uses old contents.
- Release of last busy OC at edge when all were busy: instr_ready rises next cycle.
- Reset mid-ISSUE: requests drop immediately (async), all OCs freed.

## Test plan
- Reset, warp 1, rs_a=3, rs_b=2, src_b_en=1 -> T+1 both valid same cycle: A bank 3 row 2, B bank 2 row 2, req_ocid 0, oc_busy 4'b0001.
- Warp 1, rs_a=3, rs_b=7 (both bank 3; A row 2, B row 3), req_a_ready held 0 for 3 cycles -> B never valid until cycle after A handshake; then B bank 3 row 3.
- Four back-to-back instructions with no releases -> ocids 0,1,2,3, oc_busy 4'b1111, instr_ready 0; release id 2 -> next cycle ready 1, next allocation ocid 2.
- Release id 1 and 3, rr_ptr=0 with OC0 busy -> next allocation 1, then 3 (wrap order).
- lut_we entry 4 = 4'b1011 same edge as accept of warp 1 rs_a=0 -> A bank 0 row 2 (old); next instruction rs_a=1 -> bank 3 row 5.
- Assert rst during ISSUE with req_a_valid high -> req_a_valid 0 immediately, oc_busy 0, instr_ready 1 after deassert.

Source files
------------

// File: rtl/oc_dispatch_ctrl_if.sv
// Instruction-offer and bank-read-request bundle of the operand-collector
// dispatch controller. The slave side is the dispatch controller; the master
// side is the issue unit plus the bank arbiter that accepts read requests.
interface oc_dispatch_ctrl_if #(
   parameter int NUM_OC   = 4,
   parameter int NUM_WARP = 8,
   parameter int ROW_W    = 3
);
   localparam int OC_W   = $clog2(NUM_OC);
   localparam int WARP_W = $clog2(NUM_WARP);

   // instruction offer from the issue unit
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [WARP_W-1:0] hw_warp;

   // operand A bank read request
   logic              req_a_valid;
   logic              req_a_ready;
   logic [1:0]        req_a_bank;
   logic [ROW_W-1:0]  req_a_row;

   // operand B bank read request
   logic              req_b_valid;
   logic              req_b_ready;
   logic [1:0]        req_b_bank;
   logic [ROW_W-1:0]  req_b_row;

   // collector that owns the outstanding requests
   logic [OC_W-1:0]   req_ocid;

   modport master (
      output instr_valid, instr, hw_warp, req_a_ready, req_b_ready,
      input  instr_ready, req_a_valid, req_a_bank, req_a_row,
             req_b_valid, req_b_bank, req_b_row, req_ocid
   );

   modport slave (
      input  instr_valid, instr, hw_warp, req_a_ready, req_b_ready,
      output instr_ready, req_a_valid, req_a_bank, req_a_row,
             req_b_valid, req_b_bank, req_b_row, req_ocid
   );
endinterface

// File: rtl/oc_dispatch_ctrl.sv
// Operand-collector dispatch controller for the register-read stage.
// Accepts one decoded instruction at a time, allocates a free collector
// round-robin, maps up to two source registers through a per-warp table into
// bank/row addresses and issues the bank reads on two handshaked ports.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no requests outstanding; accept an instruction if an OC is free
//   ISSUE | bank reads of the accepted instruction still pending
//
// Operand B is held back while A is pending if both hit the same bank, so a
// single bank never sees two reads from one instruction in the same cycle.
module oc_dispatch_ctrl #(
   parameter int   NUM_OC   = 4,
   parameter int   NUM_WARP = 8,
   parameter int   ROW_W    = 3,
   localparam int  OC_W     = $clog2(NUM_OC),
   localparam int  WARP_W   = $clog2(NUM_WARP),
   localparam int  EW       = ROW_W + 1,
   localparam int  NUM_ENT  = NUM_WARP * 4
) (
   input  logic                clk,
   input  logic                rst,
   oc_dispatch_ctrl_if.slave   bus,
   input  logic                lut_we_i,
   input  logic [WARP_W+1:0]   lut_waddr_i,
   input  logic [EW-1:0]       lut_wdata_i,
   input  logic                oc_release_valid_i,
   input  logic [OC_W-1:0]     oc_release_id_i,
   output logic [NUM_OC-1:0]   oc_busy_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t              state_q;
   logic                pend_a_q, pend_b_q;
   logic [1:0]          bank_a_q, bank_b_q;
   logic [ROW_W-1:0]    row_a_q, row_b_q;
   logic [OC_W-1:0]     ocid_q;
   logic [OC_W-1:0]     rr_ptr_q;
   logic [NUM_OC-1:0]   busy_q, busy_d;

   logic [EW-1:0]       lut_q [NUM_ENT];

   logic [2:0]          rs_a, rs_b;
   logic                src_b_en;
   logic [WARP_W+1:0]   idx_a, idx_b;
   logic [EW-1:0]       ent_a, ent_b;
   logic [1:0]          map_bank_a, map_bank_b;
   logic [ROW_W-1:0]    map_row_a, map_row_b;

   logic                alloc_found;
   logic [OC_W-1:0]     alloc_id;
   logic [OC_W-1:0]     alloc_next;

   logic                accept;
   logic                conflict;
   logic                req_b_valid;
   logic                hs_a, hs_b;
   logic                pend_a_n, pend_b_n;

   logic                unused_instr_bits;

   assign rs_a     = bus.instr[23:21];
   assign rs_b     = bus.instr[18:16];
   assign src_b_en = bus.instr[24];
   assign unused_instr_bits = ^{bus.instr[31:25], bus.instr[20:19], bus.instr[15:0]};

   // Table lookup: entry selected by warp and the upper two register bits;
   // the register LSB picks the bank within the pair chosen by the entry.
   assign idx_a      = {bus.hw_warp, rs_a[2:1]};
   assign idx_b      = {bus.hw_warp, rs_b[2:1]};
   assign ent_a      = lut_q[idx_a];
   assign ent_b      = lut_q[idx_b];
   assign map_bank_a = {ent_a[0], rs_a[0]};
   assign map_bank_b = {ent_b[0], rs_b[0]};
   assign map_row_a  = ent_a[EW-1:1];
   assign map_row_b  = ent_b[EW-1:1];

   // Round-robin search for the first free collector at or above rr_ptr.
   // Scanning from the far end lets the nearest free slot win last.
   always_comb begin
      int             idx;
      logic [OC_W-1:0] cand;
      alloc_found = 1'b0;
      alloc_id    = '0;
      idx         = 0;
      cand        = '0;
      for (int k = NUM_OC - 1; k >= 0; k--) begin
         idx  = (int'(rr_ptr_q) + k) % NUM_OC;
         cand = OC_W'(idx);
         if (!busy_q[cand]) begin
            alloc_found = 1'b1;
            alloc_id    = cand;
         end
      end
   end

   assign alloc_next = (int'(alloc_id) == NUM_OC - 1) ? '0 : alloc_id + 1'b1;

   assign bus.instr_ready = (state_q == IDLE) && !(&busy_q);
   assign accept          = bus.instr_valid && bus.instr_ready;

   assign conflict    = pend_b_q && (bank_a_q == bank_b_q);
   assign req_b_valid = pend_b_q && !(conflict && pend_a_q);
   assign hs_a        = pend_a_q && bus.req_a_ready;
   assign hs_b        = req_b_valid && bus.req_b_ready;
   assign pend_a_n    = pend_a_q && !hs_a;
   assign pend_b_n    = pend_b_q && !hs_b;

   // Occupancy next state: releases clear first, then the new allocation sets,
   // so a stray release aimed at the slot being allocated cannot undo it.
   always_comb begin
      busy_d = busy_q;
      if (oc_release_valid_i && (int'(oc_release_id_i) < NUM_OC)) begin
         busy_d[oc_release_id_i] = 1'b0;
      end
      if (accept && alloc_found) begin
         busy_d[alloc_id] = 1'b1;
      end
   end

   // Mapping table; writes land at the edge, so a same-edge lookup sees old data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENT; i++) begin
            lut_q[i] <= EW'(i);
         end
      end else if (lut_we_i) begin
         lut_q[lut_waddr_i] <= lut_wdata_i;
      end
   end

   // Dispatch FSM with registered request fields and occupancy tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pend_a_q <= 1'b0;
         pend_b_q <= 1'b0;
         bank_a_q <= '0;
         bank_b_q <= '0;
         row_a_q  <= '0;
         row_b_q  <= '0;
         ocid_q   <= '0;
         rr_ptr_q <= '0;
         busy_q   <= '0;
      end else begin
         busy_q <= busy_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  ocid_q   <= alloc_id;
                  rr_ptr_q <= alloc_next;
                  bank_a_q <= map_bank_a;
                  row_a_q  <= map_row_a;
                  bank_b_q <= map_bank_b;
                  row_b_q  <= map_row_b;
                  pend_a_q <= 1'b1;
                  pend_b_q <= src_b_en;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               pend_a_q <= pend_a_n;
               pend_b_q <= pend_b_n;
               if (!pend_a_n && !pend_b_n) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_a_valid = pend_a_q;
   assign bus.req_a_bank  = bank_a_q;
   assign bus.req_a_row   = row_a_q;
   assign bus.req_b_valid = req_b_valid;
   assign bus.req_b_bank  = bank_b_q;
   assign bus.req_b_row   = row_b_q;
   assign bus.req_ocid    = ocid_q;
   assign oc_busy_o       = busy_q;

endmodule

// File: tb/tb_oc_dispatch_ctrl.sv
// Directed bench for the operand-collector dispatch controller.
module tb_oc_dispatch_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       lut_we;
   logic [4:0] lut_waddr;
   logic [3:0] lut_wdata;
   logic       rel_valid;
   logic [1:0] rel_id;
   logic [3:0] oc_busy;

   int vec     = 0;
   int miscmp  = 0;

   oc_dispatch_ctrl_if bus ();

   oc_dispatch_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .bus                (bus.slave),
      .lut_we_i           (lut_we),
      .lut_waddr_i        (lut_waddr),
      .lut_wdata_i        (lut_wdata),
      .oc_release_valid_i (rel_valid),
      .oc_release_id_i    (rel_id),
      .oc_busy_o          (oc_busy)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic ben, input logic [2:0] ra, input logic [2:0] rb);
      logic [31:0] w;
      w        = 32'h0;
      w[24]    = ben;
      w[23:21] = ra;
      w[18:16] = rb;
      return w;
   endfunction

   // Offer an instruction, wait (bounded) for ready, return one ns after the
   // accepting edge, i.e. at the start of cycle T+1.
   task automatic offer(input logic [2:0] w, input logic [2:0] ra, input logic [2:0] rb, input logic ben);
      int n;
      n = 0;
      bus.instr       = mk(ben, ra, rb);
      bus.hw_warp     = w;
      bus.instr_valid = 1'b1;
      #1;
      while (!bus.instr_ready && n < 20) begin
         cyc();
         n++;
      end
      vec++;
      if (bus.instr_ready !== 1'b1) begin
         $display("FAIL offer_timeout instr_ready=%b want 1", bus.instr_ready);
         miscmp++;
      end
      cyc();
      bus.instr_valid = 1'b0;
      #1;
   endtask

   task automatic release_oc(input logic [1:0] id);
      rel_valid = 1'b1;
      rel_id    = id;
      cyc();
      rel_valid = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = 32'h0;
      bus.hw_warp     = 3'd0;
      bus.req_a_ready = 1'b1;
      bus.req_b_ready = 1'b1;
      lut_we          = 1'b0;
      lut_waddr       = 5'd0;
      lut_wdata       = 4'd0;
      rel_valid       = 1'b0;
      rel_id          = 2'd0;
      cyc();
      cyc();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      vec++; if (bus.instr_ready !== 1'b1) begin $display("FAIL rst_ready got %b want 1", bus.instr_ready); miscmp++; end
      vec++; if (oc_busy !== 4'b0000) begin $display("FAIL rst_busy got %b want 0000", oc_busy); miscmp++; end
      vec++; if ({bus.req_a_valid, bus.req_b_valid} !== 2'b00) begin $display("FAIL rst_valid got %b want 00", {bus.req_a_valid, bus.req_b_valid}); miscmp++; end
      vec++; if ({bus.req_ocid, bus.req_a_bank, bus.req_a_row, bus.req_b_bank, bus.req_b_row} !== 12'h0) begin
         $display("FAIL rst_fields got %h want 000", {bus.req_ocid, bus.req_a_bank, bus.req_a_row, bus.req_b_bank, bus.req_b_row}); miscmp++; end
   endtask

   task automatic test_dual_issue();
      offer(3'd1, 3'd3, 3'd2, 1'b1);
      vec++; if ({bus.req_a_valid, bus.req_b_valid} !== 2'b11) begin $display("FAIL dual_valid got %b want 11", {bus.req_a_valid, bus.req_b_valid}); miscmp++; end
      vec++; if ({bus.req_a_bank, bus.req_a_row} !== {2'd3, 3'd2}) begin $display("FAIL dual_a got bank %0d row %0d want 3 2", bus.req_a_bank, bus.req_a_row); miscmp++; end
      vec++; if ({bus.req_b_bank, bus.req_b_row} !== {2'd2, 3'd2}) begin $display("FAIL dual_b got bank %0d row %0d want 2 2", bus.req_b_bank, bus.req_b_row); miscmp++; end
      vec++; if (bus.req_ocid !== 2'd0) begin $display("FAIL dual_ocid got %0d want 0", bus.req_ocid); miscmp++; end
      vec++; if (oc_busy !== 4'b0001) begin $display("FAIL dual_busy got %b want 0001", oc_busy); miscmp++; end
      vec++; if (bus.instr_ready !== 1'b0) begin $display("FAIL dual_ready_issue got %b want 0", bus.instr_ready); miscmp++; end
      cyc();
      vec++; if ({bus.req_a_valid, bus.req_b_valid, bus.instr_ready} !== 3'b001) begin
         $display("FAIL dual_done got %b want 001", {bus.req_a_valid, bus.req_b_valid, bus.instr_ready}); miscmp++; end
      release_oc(2'd0);
      vec++; if (oc_busy !== 4'b0000) begin $display("FAIL dual_release got %b want 0000", oc_busy); miscmp++; end
   endtask

   task automatic test_conflict();
      bus.req_a_ready = 1'b0;
      bus.req_b_ready = 1'b1;
      offer(3'd1, 3'd3, 3'd7, 1'b1);
      vec++; if (bus.req_ocid !== 2'd1) begin $display("FAIL conf_ocid got %0d want 1", bus.req_ocid); miscmp++; end
      for (int i = 0; i < 3; i++) begin
         vec++; if ({bus.req_a_valid, bus.req_b_valid} !== 2'b10) begin $display("FAIL conf_hold%0d got %b want 10", i, {bus.req_a_valid, bus.req_b_valid}); miscmp++; end
         vec++; if ({bus.req_a_bank, bus.req_a_row} !== {2'd3, 3'd2}) begin $display("FAIL conf_a%0d got bank %0d row %0d want 3 2", i, bus.req_a_bank, bus.req_a_row); miscmp++; end
         cyc();
      end
      bus.req_a_ready = 1'b1;
      #1;
      vec++; if (bus.req_b_valid !== 1'b0) begin $display("FAIL conf_b_during_hs got %b want 0", bus.req_b_valid); miscmp++; end
      cyc();
      vec++; if ({bus.req_a_valid, bus.req_b_valid} !== 2'b01) begin $display("FAIL conf_b_after got %b want 01", {bus.req_a_valid, bus.req_b_valid}); miscmp++; end
      vec++; if ({bus.req_b_bank, bus.req_b_row} !== {2'd3, 3'd3}) begin $display("FAIL conf_b got bank %0d row %0d want 3 3", bus.req_b_bank, bus.req_b_row); miscmp++; end
      cyc();
      vec++; if ({bus.req_b_valid, bus.instr_ready} !== 2'b01) begin $display("FAIL conf_done got %b want 01", {bus.req_b_valid, bus.instr_ready}); miscmp++; end
      release_oc(2'd1);
   endtask

   task automatic fill_four(input string tag);
      for (int i = 0; i < 4; i++) begin
         offer(3'd0, 3'd0, 3'd0, 1'b0);
         vec++; if (bus.req_ocid !== 2'(i)) begin $display("FAIL %s_ocid%0d got %0d want %0d", tag, i, bus.req_ocid, i); miscmp++; end
         cyc();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fill_four("b2b");
      vec++; if (oc_busy !== 4'b1111) begin $display("FAIL b2b_busy got %b want 1111", oc_busy); miscmp++; end
      vec++; if (bus.instr_ready !== 1'b0) begin $display("FAIL b2b_full_ready got %b want 0", bus.instr_ready); miscmp++; end
      rel_valid = 1'b1;
      rel_id    = 2'd2;
      #1;
      vec++; if (bus.instr_ready !== 1'b0) begin $display("FAIL b2b_no_bypass got %b want 0", bus.instr_ready); miscmp++; end
      cyc();
      rel_valid = 1'b0;
      #1;
      vec++; if (bus.instr_ready !== 1'b1) begin $display("FAIL b2b_freed_ready got %b want 1", bus.instr_ready); miscmp++; end
      offer(3'd0, 3'd0, 3'd0, 1'b0);
      vec++; if (bus.req_ocid !== 2'd2) begin $display("FAIL b2b_realloc got %0d want 2", bus.req_ocid); miscmp++; end
      cyc();
   endtask

   task automatic test_wrap();
      do_reset();
      fill_four("wrap");
      release_oc(2'd1);
      release_oc(2'd3);
      vec++; if (oc_busy !== 4'b0101) begin $display("FAIL wrap_busy got %b want 0101", oc_busy); miscmp++; end
      offer(3'd0, 3'd0, 3'd0, 1'b0);
      vec++; if (bus.req_ocid !== 2'd1) begin $display("FAIL wrap_first got %0d want 1", bus.req_ocid); miscmp++; end
      cyc();
      offer(3'd0, 3'd0, 3'd0, 1'b0);
      vec++; if (bus.req_ocid !== 2'd3) begin $display("FAIL wrap_second got %0d want 3", bus.req_ocid); miscmp++; end
      cyc();
      vec++; if (oc_busy !== 4'b1111) begin $display("FAIL wrap_full got %b want 1111", oc_busy); miscmp++; end
   endtask

   task automatic test_lut_same_edge();
      do_reset();
      lut_we    = 1'b1;
      lut_waddr = 5'd4;
      lut_wdata = 4'b1011;
      offer(3'd1, 3'd0, 3'd0, 1'b0);
      lut_we = 1'b0;
      vec++; if ({bus.req_a_bank, bus.req_a_row} !== {2'd0, 3'd2}) begin $display("FAIL lut_old got bank %0d row %0d want 0 2", bus.req_a_bank, bus.req_a_row); miscmp++; end
      vec++; if (bus.req_b_valid !== 1'b0) begin $display("FAIL lut_no_b got %b want 0", bus.req_b_valid); miscmp++; end
      cyc();
      offer(3'd1, 3'd1, 3'd0, 1'b0);
      vec++; if ({bus.req_a_bank, bus.req_a_row} !== {2'd3, 3'd5}) begin $display("FAIL lut_new got bank %0d row %0d want 3 5", bus.req_a_bank, bus.req_a_row); miscmp++; end
      cyc();
   endtask

   task automatic test_reset_mid_issue();
      bus.req_a_ready = 1'b0;
      offer(3'd0, 3'd0, 3'd0, 1'b0);
      vec++; if (bus.req_a_valid !== 1'b1) begin $display("FAIL mid_pre got %b want 1", bus.req_a_valid); miscmp++; end
      #2;
      rst = 1'b1;
      #1;
      vec++; if (bus.req_a_valid !== 1'b0) begin $display("FAIL mid_async_drop got %b want 0", bus.req_a_valid); miscmp++; end
      vec++; if (oc_busy !== 4'b0000) begin $display("FAIL mid_busy got %b want 0000", oc_busy); miscmp++; end
      cyc();
      rst = 1'b0;
      bus.req_a_ready = 1'b1;
      #1;
      vec++; if ({bus.instr_ready, bus.req_a_valid} !== 2'b10) begin $display("FAIL mid_after got %b want 10", {bus.instr_ready, bus.req_a_valid}); miscmp++; end
   endtask

   initial begin
      test_reset();
      test_dual_issue();
      test_conflict();
      test_back_to_back();
      test_wrap();
      test_lut_same_edge();
      test_reset_mid_issue();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end
endmodule
